// File: rtl/bomb_pkg.sv
// Shared types and helpers for the bomb scheduler: slot states, player indices,
// counter sizing and the Chebyshev blast-radius test.
package bomb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } slot_state_e;

    localparam logic RED  = 1'b0;
    localparam logic BLUE = 1'b1;

    // Counter width large enough to hold both the fuse and the stun load values.
    function automatic int cnt_width(input int f, input int s);
        int m;
        m = (f > s) ? f : s;
        return $clog2(m + 1);
    endfunction

    // Distances are taken as 5-bit magnitudes so the grid edge never wraps.
    function automatic logic in_blast(input logic [3:0] bx, input logic [3:0] by,
                                      input logic [3:0] px, input logic [3:0] py,
                                      input int radius);
        logic [4:0] dx;
        logic [4:0] dy;
        dx = (bx >= px) ? ({1'b0, bx} - {1'b0, px}) : ({1'b0, px} - {1'b0, bx});
        dy = (by >= py) ? ({1'b0, by} - {1'b0, py}) : ({1'b0, py} - {1'b0, by});
        return (int'(dx) <= radius) && (int'(dy) <= radius);
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One player's bomb slot: arms on an accepted drop, runs the fuse, then waits
// in PENDING until the shared evaluator grants it.
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int F_CYC = 1000,
    parameter int CNT_W = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_drop,
    input  logic       i_stun,
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic       i_grant,
    output logic       o_req,
    output logic       o_active,
    output logic [3:0] o_x,
    output logic [3:0] o_y
);

    slot_state_e      r_state;
    slot_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_x;
    logic [3:0]       r_y;
    logic [3:0]       w_x_nxt;
    logic [3:0]       w_y_nxt;

    // State, fuse counter and latched position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_x     <= 4'd0;
            r_y     <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    // Next-state logic; drops outside IDLE or while stunned fall through untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        case (r_state)
            IDLE: begin
                if (i_drop && !i_stun) begin
                    w_state_nxt = ARMED;
                    w_cnt_nxt   = CNT_W'(F_CYC - 1);
                    w_x_nxt     = i_x;
                    w_y_nxt     = i_y;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ARMED: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = PENDING;
                end else begin
                    w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            PENDING: begin
                if (i_grant) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = PENDING;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_req    = (r_state == PENDING);
    assign o_active = (r_state != IDLE);
    assign o_x      = r_x;
    assign o_y      = r_y;

endmodule

// File: rtl/bomb_controller.sv
// Bomb scheduler top: two bomb slots, a round-robin blast evaluator that hit-tests
// both players, and per-player stun timers.
module bomb_controller
    import bomb_pkg::*;
#(
    parameter int TICKS_PER_SEC = 500,
    parameter int FUSE_SEC      = 2,
    parameter int STUN_SEC      = 2,
    parameter int RADIUS        = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       red_drop,
    input  logic       blue_drop,
    input  logic [3:0] red_x,
    input  logic [3:0] red_y,
    input  logic [3:0] blue_x,
    input  logic [3:0] blue_y,
    output logic       red_bomb_active,
    output logic       blue_bomb_active,
    output logic [3:0] red_bomb_x,
    output logic [3:0] red_bomb_y,
    output logic [3:0] blue_bomb_x,
    output logic [3:0] blue_bomb_y,
    output logic       red_blast,
    output logic       blue_blast,
    output logic       red_stun,
    output logic       blue_stun
);

    localparam int F     = FUSE_SEC * TICKS_PER_SEC;
    localparam int S     = STUN_SEC * TICKS_PER_SEC;
    localparam int CNT_W = cnt_width(F, S);

    logic             w_red_req;
    logic             w_blue_req;
    logic             w_grant_red;
    logic             w_grant_blue;
    logic             w_any_grant;
    logic             w_tie;
    logic [3:0]       w_bx;
    logic [3:0]       w_by;
    logic             w_red_hit;
    logic             w_blue_hit;
    logic             w_red_stun;
    logic             w_blue_stun;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_red_stun_cnt;
    logic [CNT_W-1:0] r_blue_stun_cnt;
    logic             r_red_blast;
    logic             r_blue_blast;

    assign w_red_stun  = (r_red_stun_cnt != {CNT_W{1'b0}});
    assign w_blue_stun = (r_blue_stun_cnt != {CNT_W{1'b0}});

    bomb_slot #(.F_CYC(F), .CNT_W(CNT_W)) u_red_slot (
        .clk      (clk),
        .reset    (reset),
        .i_drop   (red_drop),
        .i_stun   (w_red_stun),
        .i_x      (red_x),
        .i_y      (red_y),
        .i_grant  (w_grant_red),
        .o_req    (w_red_req),
        .o_active (red_bomb_active),
        .o_x      (red_bomb_x),
        .o_y      (red_bomb_y)
    );

    bomb_slot #(.F_CYC(F), .CNT_W(CNT_W)) u_blue_slot (
        .clk      (clk),
        .reset    (reset),
        .i_drop   (blue_drop),
        .i_stun   (w_blue_stun),
        .i_x      (blue_x),
        .i_y      (blue_y),
        .i_grant  (w_grant_blue),
        .o_req    (w_blue_req),
        .o_active (blue_bomb_active),
        .o_x      (blue_bomb_x),
        .o_y      (blue_bomb_y)
    );

    assign w_tie = w_red_req && w_blue_req;

    // Single-grant evaluator; ties go to the slot that did not win the previous tie.
    always_comb begin
        w_grant_red  = 1'b0;
        w_grant_blue = 1'b0;
        if (w_tie) begin
            if (r_last_grant == BLUE) begin
                w_grant_red = 1'b1;
            end else begin
                w_grant_blue = 1'b1;
            end
        end else begin
            w_grant_red  = w_red_req;
            w_grant_blue = w_blue_req;
        end
    end

    // Only contended grants move the pointer; the loser's follow-up solo grant does
    // not, so consecutive simultaneous pairs alternate which colour blasts first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= BLUE;
        end else if (w_tie) begin
            r_last_grant <= w_grant_red ? RED : BLUE;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    assign w_any_grant = w_grant_red || w_grant_blue;
    assign w_bx        = w_grant_red ? red_bomb_x : blue_bomb_x;
    assign w_by        = w_grant_red ? red_bomb_y : blue_bomb_y;
    assign w_red_hit   = w_any_grant && in_blast(w_bx, w_by, red_x, red_y, RADIUS);
    assign w_blue_hit  = w_any_grant && in_blast(w_bx, w_by, blue_x, blue_y, RADIUS);

    // Stun timers: a hit reloads to the full length, otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_red_stun_cnt  <= {CNT_W{1'b0}};
            r_blue_stun_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_red_hit) begin
                r_red_stun_cnt <= CNT_W'(S);
            end else if (w_red_stun) begin
                r_red_stun_cnt <= r_red_stun_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_red_stun_cnt <= r_red_stun_cnt;
            end
            if (w_blue_hit) begin
                r_blue_stun_cnt <= CNT_W'(S);
            end else if (w_blue_stun) begin
                r_blue_stun_cnt <= r_blue_stun_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_blue_stun_cnt <= r_blue_stun_cnt;
            end
        end
    end

    // Blast pulses follow the grant by one edge, aligned with the slot leaving PENDING.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_red_blast  <= 1'b0;
            r_blue_blast <= 1'b0;
        end else begin
            r_red_blast  <= w_grant_red;
            r_blue_blast <= w_grant_blue;
        end
    end

    assign red_blast  = r_red_blast;
    assign blue_blast = r_blue_blast;
    assign red_stun   = w_red_stun;
    assign blue_stun  = w_blue_stun;

endmodule
